// File: rtl/game_controller.sv
// Whac-A-Mole game sequencer: pre-start countdown, timer control, saturating score.
// Optional high-score tracking is built when GAME_CONTROLLER_HIGH_SCORE_EN is defined.
//
// state      | meaning
// IDLE       | waiting for start; pause/hit ignored
// PRESTART   | 3-2-1 countdown, timer held at full length
// PLAYING    | timer running, hits scored
// PAUSED     | timer frozen, hits ignored; start aborts to IDLE
// GAME_OVER  | score held until the next start

module game_controller #(
    parameter int GAME_LENGTH_SECONDS = 20,
    parameter int CLKS_PER_MS         = 50000,
    parameter int PRESTART_SECONDS    = 3,
    parameter int SCORE_W             = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        pause,
    input  logic                                        hit,
    input  logic [$clog2(1000*GAME_LENGTH_SECONDS)-1:0] time_ms,
    output logic                                        timer_rst,
    output logic                                        timer_enable,
    output logic [2:0]                                  state,
    output logic [$clog2(PRESTART_SECONDS+1)-1:0]       prestart_sec,
    output logic [SCORE_W-1:0]                          score,
    output logic [SCORE_W-1:0]                          high_score,
    output logic                                        game_over
);

    localparam int SEC_W = $clog2(PRESTART_SECONDS + 1);
    localparam int CLK_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int MS_W  = 10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESTART  = 3'd1,
        S_PLAYING   = 3'd2,
        S_PAUSED    = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CLK_W-1:0]   clk_cnt;
    logic [MS_W-1:0]    ms_cnt;
    logic [SCORE_W-1:0] score_d;
    logic               ms_tick;
    logic               sec_tick;
    logic               enter_prestart;
    logic               abort;

    // Down-counters: a millisecond ends when clk_cnt hits zero, a second when
    // both counters are zero together.
    assign ms_tick        = (clk_cnt == '0);
    assign sec_tick       = ms_tick && (ms_cnt == '0);
    assign enter_prestart = (state_d == S_PRESTART) && (state_q != S_PRESTART);
    assign abort          = (state_q == S_PAUSED) && (state_d == S_IDLE);
    assign state          = state_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PRESTART;
                end
            end
            S_PRESTART: begin
                if (sec_tick && (prestart_sec == SEC_W'(1))) begin
                    state_d = S_PLAYING;
                end
            end
            S_PLAYING: begin
                // End of game takes priority over a coincident pause.
                if (time_ms == '0) begin
                    state_d = S_GAME_OVER;
                end else if (pause) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (start) begin
                    state_d = S_IDLE;
                end else if (pause) begin
                    state_d = S_PLAYING;
                end
            end
            S_GAME_OVER: begin
                if (start) begin
                    state_d = S_PRESTART;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        score_d = score;
        if (enter_prestart) begin
            score_d = '0;
        end else if ((state_q == S_PLAYING) && hit && (score != {SCORE_W{1'b1}})) begin
            score_d = score + SCORE_W'(1);
        end
    end

    // Countdown counters only move in PRESTART and are reloaded on its entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_cnt      <= '0;
            ms_cnt       <= '0;
            prestart_sec <= '0;
        end else if (enter_prestart) begin
            clk_cnt      <= CLK_W'(CLKS_PER_MS - 1);
            ms_cnt       <= MS_W'(999);
            prestart_sec <= SEC_W'(PRESTART_SECONDS);
        end else if (state_q == S_PRESTART) begin
            if (ms_tick) begin
                clk_cnt <= CLK_W'(CLKS_PER_MS - 1);
                if (ms_cnt == '0) begin
                    ms_cnt       <= MS_W'(999);
                    prestart_sec <= prestart_sec - SEC_W'(1);
                end else begin
                    ms_cnt <= ms_cnt - MS_W'(1);
                end
            end else begin
                clk_cnt <= clk_cnt - CLK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            timer_rst    <= 1'b1;
            timer_enable <= 1'b0;
            game_over    <= 1'b0;
            score        <= '0;
        end else begin
            timer_rst    <= enter_prestart || abort;
            timer_enable <= (state_d == S_PLAYING);
            game_over    <= (state_d == S_GAME_OVER);
            score        <= score_d;
        end
    end

`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    // Compare against score_d so a hit on the final cycle still counts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            high_score <= '0;
        end else if ((state_d == S_GAME_OVER) && (state_q != S_GAME_OVER)
                     && (score_d > high_score)) begin
            high_score <= score_d;
        end
    end
`else
    assign high_score = '0;
`endif

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller with a behavioural countdown timer attached.
// Expected timings and scores come from the game rules, not from the DUT.

module tb_game_controller;

    localparam int GLS      = 1;
    localparam int CPM      = 2;
    localparam int PS       = 2;
    localparam int SW       = 8;
    localparam int TW       = $clog2(1000*GLS);
    localparam int PW       = $clog2(PS+1);
    localparam int PRE_CYC  = PS*1000*CPM;
    localparam int PLAY_CYC = GLS*1000*CPM + 1;

`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, pause, hit;
    logic [TW-1:0] time_ms;
    logic          timer_rst, timer_enable, game_over;
    logic [2:0]    state;
    logic [PW-1:0] prestart_sec;
    logic [SW-1:0] score, high_score;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_model = 0;
    int e_play_g = 0;
    int t_ms = 1000*GLS;
    int t_sub = 0;

    game_controller #(
        .GAME_LENGTH_SECONDS(GLS),
        .CLKS_PER_MS(CPM),
        .PRESTART_SECONDS(PS),
        .SCORE_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .hit(hit),
        .time_ms(time_ms), .timer_rst(timer_rst), .timer_enable(timer_enable),
        .state(state), .prestart_sec(prestart_sec), .score(score),
        .high_score(high_score), .game_over(game_over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference countdown timer: reloads on timer_rst, one ms per CPM enabled clocks.
    always @(posedge clk) begin
        if (timer_rst) begin
            t_ms  <= 1000*GLS;
            t_sub <= 0;
        end else if (timer_enable && t_ms > 0) begin
            if (t_sub == CPM-1) begin
                t_sub <= 0;
                t_ms  <= t_ms - 1;
            end else begin
                t_sub <= t_sub + 1;
            end
        end
    end
    assign time_ms = TW'(t_ms);

    function automatic int exp_hs();
        return HS_EN ? hs_model : 0;
    endfunction

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start;
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_pause;
        pause = 1'b1; @(negedge clk); pause = 1'b0;
    endtask

    task automatic pulse_hit;
        hit = 1'b1; @(negedge clk); hit = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, output bit ok, output int edge_cyc);
        int n;
        n = 0;
        while (state !== s && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (state === s);
        edge_cyc = cyc;
    endtask

    task automatic start_to_playing(output bit ok, output int e_entry, output int e_play);
        pulse_start;
        e_entry = cyc;
        wait_state(3'd2, PRE_CYC + 10, ok, e_play);
    endtask

    task automatic play_game(input int n, output bit ok, output int e_play, output int e_end);
        int e_entry;
        bit ok1, ok2;
        start_to_playing(ok1, e_entry, e_play);
        for (int k = 0; k < n; k++) begin
            cyc_wait($urandom_range(1, 150));
            pulse_hit;
        end
        wait_state(3'd4, PLAY_CYC + 100, ok2, e_end);
        ok = ok1 && ok2;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; pause = 1'b0; hit = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({state, timer_rst, timer_enable, score, high_score, prestart_sec, game_over} !==
            {3'd0, 1'b1, 1'b0, {SW{1'b0}}, {SW{1'b0}}, {PW{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got state=%0d trst=%0d en=%0d score=%0d hs=%0d ps=%0d go=%0d, expected 0 1 0 0 0 0 0",
                     state, timer_rst, timer_enable, score, high_score, prestart_sec, game_over);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (timer_rst !== 1'b0 || state !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: got trst=%0d state=%0d, expected 0 0", timer_rst, state);
        end
    endtask

    task automatic test_idle_ignore;
        pulse_pause;
        pulse_hit;
        cyc_wait(2);
        checks++;
        if (state !== 3'd0 || score !== SW'(0) || timer_rst !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: got state=%0d score=%0d trst=%0d, expected 0 0 0", state, score, timer_rst);
        end
    endtask

    task automatic test_prestart;
        int e_entry, exp_sec, bad, pulses;
        pulse_start;
        e_entry = cyc;
        checks++;
        if ({state, timer_rst, prestart_sec, score} !== {3'd1, 1'b1, PW'(PS), {SW{1'b0}}}) begin
            errors++;
            $display("FAIL prestart_entry: got state=%0d trst=%0d ps=%0d score=%0d, expected 1 1 %0d 0",
                     state, timer_rst, prestart_sec, score, PS);
        end
        @(negedge clk);
        checks++;
        if (timer_rst !== 1'b0) begin
            errors++;
            $display("FAIL timer_rst_width: got %0d, expected 0 on second PRESTART cycle", timer_rst);
        end
        bad = 0;
        pulses = 0;
        while (state === 3'd1 && (cyc - e_entry) < PRE_CYC + 10) begin
            exp_sec = PS - (cyc - e_entry) / (1000*CPM);
            if (prestart_sec !== PW'(exp_sec) || timer_enable !== 1'b0) bad++;
            if (timer_rst !== 1'b0) pulses++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || pulses != 0) begin
            errors++;
            $display("FAIL prestart_countdown: got %0d bad cycles and %0d extra timer_rst, expected 0 and 0", bad, pulses);
        end
        checks++;
        if (state !== 3'd2 || (cyc - e_entry) != PRE_CYC) begin
            errors++;
            $display("FAIL prestart_duration: got state=%0d after %0d cycles, expected 2 after %0d",
                     state, cyc - e_entry, PRE_CYC);
        end
        checks++;
        if (timer_enable !== 1'b1 || prestart_sec !== PW'(0)) begin
            errors++;
            $display("FAIL playing_entry: got en=%0d ps=%0d, expected 1 0", timer_enable, prestart_sec);
        end
        e_play_g = cyc;
    endtask

    task automatic test_play_score;
        int e_end;
        bit ok;
        for (int k = 0; k < 5; k++) begin
            cyc_wait($urandom_range(1, 200));
            pulse_hit;
        end
        wait_state(3'd4, PLAY_CYC + 100, ok, e_end);
        checks++;
        if (!ok || (e_end - e_play_g) != PLAY_CYC) begin
            errors++;
            $display("FAIL game_end_time: got %0d cycles (reached=%0d), expected %0d", e_end - e_play_g, ok, PLAY_CYC);
        end
        checks++;
        if (score !== SW'(5)) begin
            errors++;
            $display("FAIL score_five: got %0d, expected 5", score);
        end
        checks++;
        if (game_over !== 1'b1 || timer_enable !== 1'b0 || time_ms !== TW'(0)) begin
            errors++;
            $display("FAIL game_over_outputs: got go=%0d en=%0d time_ms=%0d, expected 1 0 0", game_over, timer_enable, time_ms);
        end
        if (5 > hs_model) hs_model = 5;
        checks++;
        if (high_score !== SW'(exp_hs())) begin
            errors++;
            $display("FAIL high_score_game1: got %0d, expected %0d", high_score, exp_hs());
        end
    endtask

    task automatic test_pause;
        bit ok, ok2;
        int e_entry, e_play, e_end, len;
        logic [TW-1:0] t0;
        start_to_playing(ok, e_entry, e_play);
        cyc_wait($urandom_range(100, 800));
        pulse_pause;
        checks++;
        if (!ok || state !== 3'd3 || timer_enable !== 1'b0) begin
            errors++;
            $display("FAIL pause_enter: got state=%0d en=%0d (reached=%0d), expected 3 0", state, timer_enable, ok);
        end
        t0 = time_ms;
        len = $urandom_range(300, 1200);
        cyc_wait(5);
        pulse_hit;
        cyc_wait(len - 7);
        checks++;
        if (time_ms !== t0 || score !== SW'(0) || state !== 3'd3) begin
            errors++;
            $display("FAIL paused_frozen: got time_ms=%0d score=%0d state=%0d, expected %0d 0 3", time_ms, score, state, t0);
        end
        pulse_pause;
        checks++;
        if (state !== 3'd2 || timer_enable !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume: got state=%0d en=%0d, expected 2 1", state, timer_enable);
        end
        wait_state(3'd4, PLAY_CYC + 100, ok2, e_end);
        checks++;
        if (!ok2 || (e_end - e_play) != PLAY_CYC + len) begin
            errors++;
            $display("FAIL paused_game_length: got %0d cycles, expected %0d", e_end - e_play, PLAY_CYC + len);
        end
    endtask

    task automatic test_high_score;
        int scores[3];
        bit ok;
        int ep, ee;
        scores = '{7, 4, 9};
        for (int g = 0; g < 3; g++) begin
            play_game(scores[g], ok, ep, ee);
            if (scores[g] > hs_model) hs_model = scores[g];
            checks++;
            if (!ok || score !== SW'(scores[g]) || high_score !== SW'(exp_hs())) begin
                errors++;
                $display("FAIL high_score_game: game %0d got score=%0d hs=%0d (ok=%0d), expected %0d %0d",
                         g, score, high_score, ok, scores[g], exp_hs());
            end
        end
    endtask

    task automatic test_saturation;
        bit ok, ok2;
        int e_entry, e_play, e_end;
        start_to_playing(ok, e_entry, e_play);
        cyc_wait(5);
        hit = 1'b1;
        cyc_wait(300);
        hit = 1'b0;
        checks++;
        if (!ok || score !== SW'(255) || state !== 3'd2) begin
            errors++;
            $display("FAIL score_saturate: got score=%0d state=%0d, expected 255 2", score, state);
        end
        wait_state(3'd4, PLAY_CYC + 100, ok2, e_end);
        hs_model = 255;
        checks++;
        if (!ok2 || score !== SW'(255) || high_score !== SW'(exp_hs())) begin
            errors++;
            $display("FAIL saturate_end: got score=%0d hs=%0d, expected 255 %0d", score, high_score, exp_hs());
        end
    endtask

    task automatic test_reset_mid_game;
        bit ok;
        int e_entry, e_play;
        start_to_playing(ok, e_entry, e_play);
        cyc_wait(20);
        repeat (3) pulse_hit;
        rst = 1'b0;
        @(negedge clk);
        hs_model = 0;
        checks++;
        if (!ok || {state, timer_rst, timer_enable, score, high_score, prestart_sec, game_over} !==
            {3'd0, 1'b1, 1'b0, {SW{1'b0}}, {SW{1'b0}}, {PW{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_game: got state=%0d trst=%0d en=%0d score=%0d hs=%0d ps=%0d go=%0d, expected 0 1 0 0 0 0 0",
                     state, timer_rst, timer_enable, score, high_score, prestart_sec, game_over);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (timer_rst !== 1'b0 || state !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_release: got trst=%0d state=%0d, expected 0 0", timer_rst, state);
        end
    endtask

    task automatic test_final_hit;
        bit ok;
        int e_entry, e_play, e_end, k;
        start_to_playing(ok, e_entry, e_play);
        checks++;
        if (!ok || (e_play - e_entry) != PRE_CYC || score !== SW'(0)) begin
            errors++;
            $display("FAIL fresh_game: got %0d prestart cycles score=%0d, expected %0d 0", e_play - e_entry, score, PRE_CYC);
        end
        k = $urandom_range(1, 6);
        for (int i = 0; i < k; i++) begin
            cyc_wait($urandom_range(1, 100));
            pulse_hit;
        end
        e_end = e_play + PLAY_CYC;
        while (cyc < e_end - 1) @(negedge clk);
        checks++;
        if (state !== 3'd2 || time_ms !== TW'(0)) begin
            errors++;
            $display("FAIL zero_detect_edge: got state=%0d time_ms=%0d, expected 2 0", state, time_ms);
        end
        hit = 1'b1;
        pause = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        pause = 1'b0;
        if (k + 1 > hs_model) hs_model = k + 1;
        checks++;
        if (state !== 3'd4 || game_over !== 1'b1 || score !== SW'(k + 1)) begin
            errors++;
            $display("FAIL final_cycle_hit: got state=%0d go=%0d score=%0d, expected 4 1 %0d", state, game_over, score, k + 1);
        end
        checks++;
        if (high_score !== SW'(exp_hs())) begin
            errors++;
            $display("FAIL high_score_final_hit: got %0d, expected %0d", high_score, exp_hs());
        end
        pulse_hit;
        checks++;
        if (score !== SW'(k + 1) || state !== 3'd4) begin
            errors++;
            $display("FAIL game_over_hold: got score=%0d state=%0d, expected %0d 4", score, state, k + 1);
        end
    endtask

    task automatic test_abort;
        bit ok;
        int e_entry, e_play;
        start_to_playing(ok, e_entry, e_play);
        cyc_wait(10);
        pulse_pause;
        cyc_wait(3);
        pulse_start;
        checks++;
        if (!ok || state !== 3'd0 || timer_rst !== 1'b1 || timer_enable !== 1'b0) begin
            errors++;
            $display("FAIL abort_enter: got state=%0d trst=%0d en=%0d, expected 0 1 0", state, timer_rst, timer_enable);
        end
        @(negedge clk);
        checks++;
        if (timer_rst !== 1'b0 || state !== 3'd0) begin
            errors++;
            $display("FAIL abort_pulse_width: got trst=%0d state=%0d, expected 0 0", timer_rst, state);
        end
    endtask

    initial begin
        test_reset;
        test_idle_ignore;
        test_prestart;
        test_play_score;
        test_pause;
        test_high_score;
        test_saturation;
        test_reset_mid_game;
        test_final_hit;
        test_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/game_controller.md
# game_controller

Top-level game sequencer for Whac-A-Mole. Accepts debounced start/pause pulses, runs a 3-2-1 pre-start countdown, then drives the `timer` block's `rst`/`enable` and consumes its `count_down_milliseconds` to detect end of game. Counts hits into a saturating score and optionally keeps a high score across games. Sits directly upstream of `timer` and feeds the display and mole logic.

## Interface
- `GAME_LENGTH_SECONDS`, 20: game length; must match the `timer` instance.
- `CLKS_PER_MS`, 50000: clocks per millisecond (50 MHz board clock).
- `PRESTART_SECONDS`, 3: pre-start countdown length, ≥1.
- `SCORE_W`, 8: score width.

- `clk`  in  1: system clock, `CLOCK_50`.
- `rst`  in  1: synchronous, active-low reset.
- `start`  in  1: single-cycle pulse, debounced.
- `pause`  in  1: single-cycle pulse, debounced.
- `hit`  in  1: single-cycle pulse from mole logic.
- `time_ms`  in  $clog2(1000*GAME_LENGTH_SECONDS): connects to `timer.count_down_milliseconds`.
- `timer_rst`  out  1: active-high reset to `timer`.
- `timer_enable`  out  1: run enable to `timer`.
- `state`  out  3: encoded FSM state.
- `prestart_sec`  out  $clog2(PRESTART_SECONDS+1): seconds left in the pre-start countdown.
- `score`  out  SCORE_W: current score.
- `high_score`  out  SCORE_W: best score.
- `game_over`  out  1: high while in GAME_OVER.

## Operation
- States: IDLE=0, PRESTART=1, PLAYING=2, PAUSED=3, GAME_OVER=4.
- IDLE:
  - `start` → PRESTART.
  - `pause` and `hit` are ignored.
- PRESTART:
  - On the entry cycle, `timer_rst`=1 for exactly one cycle, `score` clears to 0, and `prestart_sec` loads PRESTART_SECONDS.
  - An internal ms counter (0..CLKS_PER_MS-1) and a ms-in-second counter (0..999) decrement `prestart_sec` each second.
  - Leaving `prestart_sec`==1 at the second boundary → PLAYING, with `prestart_sec`=0.
  - `start`, `pause` and `hit` are ignored.
- PLAYING:
  - `timer_enable`=1.
  - `hit` increments `score`, saturating at 2^SCORE_W−1.
  - `pause` → PAUSED.
  - `time_ms`==0 → GAME_OVER.
  - A `hit` in the same cycle as `time_ms`==0 is still counted.
  - `pause` in the same cycle as `time_ms`==0 is ignored; GAME_OVER wins.
- PAUSED:
  - `timer_enable`=0; `hit` is ignored.
  - `pause` → PLAYING.
  - `start` → IDLE (abort), with `timer_rst` pulsed for one cycle.
- GAME_OVER:
  - `game_over`=1, `timer_enable`=0, `score` is held.
  - `start` → PRESTART.
- Any unused state encoding → IDLE on the next clock.

## Timing
- Reset values (`rst`=0 at a clock edge):
  - state=IDLE.
  - `timer_rst`=1 while `rst`=0, so the timer is held in reset alongside the controller.
  - `timer_enable`=0, `score`=0, `high_score`=0, `prestart_sec`=0, `game_over`=0.
  - Internal counters are cleared.
- Reset mid-game: all of the above apply immediately on that edge; a later `start` begins a fresh game.
- All outputs are registered. Input pulse at edge N → state/score change visible after edge N.
- PRESTART duration is exactly PRESTART_SECONDS*1000*CLKS_PER_MS cycles from the entry edge to the PLAYING edge.
- `timer_enable` rises on the same edge that enters PLAYING and falls on the edge leaving it.
- `time_ms` is sampled only in PLAYING. `timer_rst` is issued on PRESTART entry, so `time_ms` has reloaded to full before PLAYING begins; there is no false zero detect.
- Ms/second counters are frozen outside PRESTART.

## Configuration
- `GAME_CONTROLLER_HIGH_SCORE_EN` defined:
  - On the GAME_OVER entry edge, if `score` > `high_score`, then `high_score` ← `score`.
  - Equal scores do not update it.
  - The final-cycle hit is included in the comparison.
  - `high_score` persists across games and clears only on `rst`.
- `GAME_CONTROLLER_HIGH_SCORE_EN` undefined: `high_score` is tied to 0 and no comparison logic is built.

## Test plan
Parameters for all scenarios: CLKS_PER_MS=50, GAME_LENGTH_SECONDS=2, PRESTART_SECONDS=3, with a real `timer` attached.
- Reset, then `start` → `timer_rst` pulses once; `prestart_sec` reads 3, 2, 1 at 50000-cycle steps; PLAYING and `timer_enable`=1 exactly 150000 cycles after entry.
- 5 hits during PLAYING, no pause → `score`=5; GAME_OVER when `time_ms`=0, about 100000 cycles after PLAYING; `game_over`=1, `timer_enable`=0.
- `pause` in PLAYING for 30000 cycles, then `pause` again → `time_ms` frozen while PAUSED; game ends 30000 cycles later than in the unpaused run.
- 300 hits with SCORE_W=8 → `score` saturates at 255. Hit and `time_ms`=0 in the same cycle → the hit is counted.
- With `GAME_CONTROLLER_HIGH_SCORE_EN`: game 1 scores 7, game 2 scores 4 → `high_score` reads 7 after both; game 3 scores 9 → 9. Without the macro → `high_score` is always 0.
- `rst`=0 for one edge mid-PLAYING → every output is at its reset value on the next cycle; `start` in PAUSED → IDLE with one `timer_rst` pulse.
